// File: rtl/sram_dma_pkg.sv
// Shared widths, mode encodings and state types for the SRAM block-copy/fill engine.
package sram_dma_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned LEN_W  = 20;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_GAP, WR_REQ, WR_WAIT, WR_GAP, DONE
    } dma_state_e;

    typedef enum logic [1:0] {
        PH_IDLE, PH_REQ, PH_WAIT, PH_GAP
    } port_phase_e;

    // Sequencer label for the direction currently owned by the request port.
    function automatic dma_state_e track_state(input port_phase_e ph, input logic is_wr,
                                               input dma_state_e cur);
        case (ph)
            PH_REQ:  return is_wr ? WR_REQ : RD_REQ;
            PH_WAIT: return is_wr ? WR_WAIT : RD_WAIT;
            PH_GAP:  return is_wr ? WR_GAP : RD_GAP;
            default: return cur;
        endcase
    endfunction

endpackage

// File: rtl/sram_req_port.sv
// One rd/wr strobe transaction against the arbiter's ack handshake, with per-phase
// timeout and a trailing strobe-low gap.
module sram_req_port
    import sram_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 1
) (
    input  logic              clk50m,
    input  logic              reset,
    input  logic              i_go,
    input  logic              i_is_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    input  logic              i_ack,
    input  logic [7:0]        i_rdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    output logic              o_rd,
    output logic              o_wr,
    output logic [7:0]        o_rdata,
    output port_phase_e       o_phase,
    output logic              o_fin,
    output logic              o_tmo
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    port_phase_e       r_phase, w_phase_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [7:0]        r_wdata, w_wdata_nx;
    logic [7:0]        r_rdata, w_rdata_nx;
    logic              r_is_write, w_is_write_nx;
    logic              r_rd, w_rd_nx;
    logic              r_wr, w_wr_nx;
    logic [TW-1:0]     r_cnt, w_cnt_nx;
    logic [GW-1:0]     r_gcnt, w_gcnt_nx;
    logic              r_fin, w_fin_nx;
    logic              r_tmo, w_tmo_nx;
    logic              w_strobe;
    logic              w_tmo_hit;
    logic              w_abort;

    assign w_strobe  = r_rd | r_wr;
    // >= so a strobe asserted on the last allowed cycle still aborts on the next one.
    assign w_tmo_hit = (r_cnt >= TW'(TIMEOUT - 1));

    always_comb begin
        w_phase_nx    = r_phase;
        w_addr_nx     = r_addr;
        w_wdata_nx    = r_wdata;
        w_is_write_nx = r_is_write;
        w_rdata_nx    = r_rdata;
        w_rd_nx       = r_rd;
        w_wr_nx       = r_wr;
        w_cnt_nx      = r_cnt + TW'(1);
        w_gcnt_nx     = r_gcnt;
        w_fin_nx      = 1'b0;
        w_tmo_nx      = 1'b0;
        w_abort       = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                w_cnt_nx = '0;
                if (i_go) begin
                    w_addr_nx     = i_addr;
                    w_wdata_nx    = i_wdata;
                    w_is_write_nx = i_is_write;
                    w_phase_nx    = PH_REQ;
                end
            end
            PH_REQ: begin
                if (w_strobe && !i_ack) begin
                    w_phase_nx = PH_WAIT;
                    w_cnt_nx   = '0;
                end else if (!w_strobe && i_ack) begin
                    w_rd_nx = !r_is_write;
                    w_wr_nx = r_is_write;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end
            PH_WAIT: begin
                if (i_ack) begin
                    if (r_rd) begin
                        w_rdata_nx = i_rdata;
                    end
                    w_rd_nx    = 1'b0;
                    w_wr_nx    = 1'b0;
                    w_gcnt_nx  = '0;
                    w_phase_nx = PH_GAP;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end
            PH_GAP: begin
                w_cnt_nx = '0;
                if (r_gcnt == GW'(GAP - 1)) begin
                    w_fin_nx   = 1'b1;
                    w_phase_nx = PH_IDLE;
                end else begin
                    w_gcnt_nx = r_gcnt + GW'(1);
                end
            end
            default: w_phase_nx = PH_IDLE;
        endcase
        if (w_abort) begin
            w_rd_nx    = 1'b0;
            w_wr_nx    = 1'b0;
            w_tmo_nx   = 1'b1;
            w_phase_nx = PH_IDLE;
        end
    end

    always_ff @(posedge clk50m) begin
        if (reset) begin
            r_phase    <= PH_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_is_write <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_cnt      <= '0;
            r_gcnt     <= '0;
            r_fin      <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_phase    <= w_phase_nx;
            r_addr     <= w_addr_nx;
            r_wdata    <= w_wdata_nx;
            r_rdata    <= w_rdata_nx;
            r_is_write <= w_is_write_nx;
            r_rd       <= w_rd_nx;
            r_wr       <= w_wr_nx;
            r_cnt      <= w_cnt_nx;
            r_gcnt     <= w_gcnt_nx;
            r_fin      <= w_fin_nx;
            r_tmo      <= w_tmo_nx;
        end
    end

    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_rd    = r_rd;
    assign o_wr    = r_wr;
    assign o_rdata = r_rdata;
    assign o_phase = r_phase;
    assign o_fin   = r_fin;
    assign o_tmo   = r_tmo;

endmodule

// File: rtl/sram_dma.sv
// Block copy / fill engine for SRAM arbiter port 1; sequences byte transactions and
// owns the address and length counters.
module sram_dma
    import sram_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 1
) (
    input  logic              clk50m,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [7:0]        i_fill_byte,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    input  logic [7:0]        i_rdata,
    output logic              o_rd,
    output logic              o_wr,
    input  logic              i_ack
);

    dma_state_e        r_state, w_state_nx;
    logic              r_mode, w_mode_nx;
    logic [ADDR_W-1:0] r_src, w_src_nx;
    logic [ADDR_W-1:0] r_dst, w_dst_nx;
    logic [LEN_W-1:0]  r_rem, w_rem_nx;
    logic [7:0]        r_fill, w_fill_nx;
    logic              r_busy, w_busy_nx;
    logic              r_done, w_done_nx;
    logic              r_err, w_err_nx;

    logic              w_go;
    logic              w_go_wr;
    logic [ADDR_W-1:0] w_go_addr;
    logic [7:0]        w_go_wdata;
    logic [7:0]        w_rbyte;
    port_phase_e       w_phase;
    logic              w_fin;
    logic              w_tmo;
    logic [ADDR_W-1:0] w_src_inc;
    logic [ADDR_W-1:0] w_dst_inc;

    assign w_src_inc = r_src + ADDR_W'(1);
    assign w_dst_inc = r_dst + ADDR_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_src_nx   = r_src;
        w_dst_nx   = r_dst;
        w_rem_nx   = r_rem;
        w_fill_nx  = r_fill;
        w_busy_nx  = r_busy;
        w_err_nx   = r_err;
        w_done_nx  = 1'b0;
        w_go       = 1'b0;
        w_go_wr    = r_mode;
        w_go_addr  = r_src;
        w_go_wdata = r_fill;
        case (r_state)
            IDLE, DONE: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
                if (i_start) begin
                    w_mode_nx = i_mode;
                    w_src_nx  = i_src_addr;
                    w_dst_nx  = i_dst_addr;
                    w_rem_nx  = i_len;
                    w_fill_nx = i_fill_byte;
                    w_err_nx  = 1'b0;
                    if (i_len == '0) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = DONE;
                    end else begin
                        w_busy_nx  = 1'b1;
                        w_go       = 1'b1;
                        w_go_wr    = i_mode;
                        w_go_addr  = (i_mode == MODE_FILL) ? i_dst_addr : i_src_addr;
                        w_go_wdata = i_fill_byte;
                        w_state_nx = (i_mode == MODE_FILL) ? WR_REQ : RD_REQ;
                    end
                end
            end
            RD_REQ, RD_WAIT, RD_GAP: begin
                if (w_tmo) begin
                    w_err_nx   = 1'b1;
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_state_nx = DONE;
                end else if (w_fin) begin
                    w_go       = 1'b1;
                    w_go_wr    = 1'b1;
                    w_go_addr  = r_dst;
                    w_go_wdata = w_rbyte;
                    w_state_nx = WR_REQ;
                end else begin
                    w_state_nx = track_state(w_phase, 1'b0, r_state);
                end
            end
            WR_REQ, WR_WAIT, WR_GAP: begin
                if (w_tmo) begin
                    w_err_nx   = 1'b1;
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_state_nx = DONE;
                end else if (w_fin) begin
                    w_src_nx = w_src_inc;
                    w_dst_nx = w_dst_inc;
                    w_rem_nx = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_done_nx  = 1'b1;
                        w_busy_nx  = 1'b0;
                        w_state_nx = DONE;
                    end else begin
                        w_go       = 1'b1;
                        w_go_wr    = r_mode;
                        w_go_addr  = (r_mode == MODE_FILL) ? w_dst_inc : w_src_inc;
                        w_go_wdata = r_fill;
                        w_state_nx = (r_mode == MODE_FILL) ? WR_REQ : RD_REQ;
                    end
                end else begin
                    w_state_nx = track_state(w_phase, 1'b1, r_state);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk50m) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= MODE_COPY;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_fill  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_src   <= w_src_nx;
            r_dst   <= w_dst_nx;
            r_rem   <= w_rem_nx;
            r_fill  <= w_fill_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    sram_req_port #(
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) u_port (
        .clk50m     (clk50m),
        .reset      (reset),
        .i_go       (w_go),
        .i_is_write (w_go_wr),
        .i_addr     (w_go_addr),
        .i_wdata    (w_go_wdata),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_rd       (o_rd),
        .o_wr       (o_wr),
        .o_rdata    (w_rbyte),
        .o_phase    (w_phase),
        .o_fin      (w_fin),
        .o_tmo      (w_tmo)
    );

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule

// File: tb/tb_sram_dma.sv
// Directed bench for sram_dma against a small ack-handshake arbiter/SRAM model.
module tb_sram_dma;
    import sram_dma_pkg::*;

    logic              clk50m = 1'b0;
    logic              reset  = 1'b1;
    logic              i_start = 1'b0;
    logic              i_mode = 1'b0;
    logic [ADDR_W-1:0] i_src_addr = '0;
    logic [ADDR_W-1:0] i_dst_addr = '0;
    logic [LEN_W-1:0]  i_len = '0;
    logic [7:0]        i_fill_byte = '0;
    logic              o_busy, o_done, o_err, o_rd, o_wr;
    logic [ADDR_W-1:0] o_addr;
    logic [7:0]        o_wdata;

    // Arbiter model state
    logic              r_ack_m = 1'b1;
    logic [7:0]        r_rdata_m = 8'h00;
    logic              m_busy = 1'b0;
    logic              m_seen = 1'b0;
    logic              m_wr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [7:0]        m_wdata = '0;
    int                m_cnt = 0;
    int                txn_cnt = 0;
    int                long_idx = -1;
    int                long_len = 0;
    logic [7:0]        mem [0:1023];
    logic [19:0]       op_q [$];
    logic [7:0]        wd_q [$];

    int n_checks = 0;
    int n_err = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int fresh_bad = 0;
    logic chk_fresh = 1'b0;
    logic prev_wr = 1'b0;

    sram_dma #(
        .TIMEOUT (64),
        .GAP     (1)
    ) dut (
        .clk50m      (clk50m),
        .reset       (reset),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_src_addr  (i_src_addr),
        .i_dst_addr  (i_dst_addr),
        .i_len       (i_len),
        .i_fill_byte (i_fill_byte),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_addr      (o_addr),
        .o_wdata     (o_wdata),
        .i_rdata     (r_rdata_m),
        .o_rd        (o_rd),
        .o_wr        (o_wr),
        .i_ack       (r_ack_m)
    );

    always #10 clk50m = ~clk50m;

    // Accept on a fresh strobe while idle, drop ack, complete after the hold time.
    always @(posedge clk50m) begin
        if (!o_rd && !o_wr) m_seen <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                r_ack_m <= 1'b1;
                m_busy  <= 1'b0;
                if (m_wr) begin
                    mem[m_addr[9:0]] = m_wdata;
                    op_q.push_back({1'b1, m_addr});
                    wd_q.push_back(m_wdata);
                end else begin
                    r_rdata_m <= mem[m_addr[9:0]];
                    op_q.push_back({1'b0, m_addr});
                    wd_q.push_back(mem[m_addr[9:0]]);
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if ((o_rd || o_wr) && r_ack_m && !m_seen) begin
            r_ack_m <= 1'b0;
            m_busy  <= 1'b1;
            m_seen  <= 1'b1;
            m_wr    <= o_wr;
            m_addr  <= o_addr;
            m_wdata <= o_wdata;
            m_cnt   <= (txn_cnt == long_idx) ? long_len - 1 : 2;
            txn_cnt <= txn_cnt + 1;
        end
    end

    always @(posedge clk50m) begin
        if (o_done === 1'b1) done_cnt <= done_cnt + 1;
        if (o_rd === 1'b1 && o_wr === 1'b1) both_cnt <= both_cnt + 1;
        if (chk_fresh && o_wr && !prev_wr && !r_ack_m) fresh_bad <= fresh_bad + 1;
        prev_wr <= o_wr;
    end

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic mode, input logic [ADDR_W-1:0] src,
                              input logic [ADDR_W-1:0] dst, input logic [LEN_W-1:0] len,
                              input logic [7:0] fill);
        i_mode = mode;
        i_src_addr = src;
        i_dst_addr = dst;
        i_len = len;
        i_fill_byte = fill;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(o_done), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((!r_ack_m || m_busy) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_model_idle"}, 32'(r_ack_m), 32'd1);
    endtask

    initial begin
        int base;
        int d0;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'h11;
        exp_b[1] = 8'h22;
        exp_b[2] = 8'h33;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        // Reset values
        repeat (3) tick();
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_rd", 32'(o_rd), 0);
        check("rst_wr", 32'(o_wr), 0);
        check("rst_addr", 32'(o_addr), 0);
        check("rst_wdata", 32'(o_wdata), 0);
        reset = 1'b0;
        tick();

        // Fill 4 bytes of A5 at 0x100
        base = op_q.size();
        d0 = done_cnt;
        start_xfer(MODE_FILL, 19'h0, 19'h00100, 20'd4, 8'hA5);
        check("fill_busy", 32'(o_busy), 1);
        wait_done(400, "fill");
        check("fill_err", 32'(o_err), 0);
        tick();
        check("fill_done_low", 32'(o_done), 0);
        check("fill_busy_low", 32'(o_busy), 0);
        check("fill_done_width", 32'(done_cnt - d0), 1);
        check("fill_nops", 32'(op_q.size() - base), 4);
        for (int i = 0; i < 4; i++) begin
            check("fill_op", 32'(op_q[base+i]), 32'({1'b1, 19'h00100 + 19'(i)}));
            check("fill_data", 32'(wd_q[base+i]), 32'h0A5);
        end

        // Copy 3 bytes 0x10 -> 0x80
        mem[10'h010] = 8'h11;
        mem[10'h011] = 8'h22;
        mem[10'h012] = 8'h33;
        base = op_q.size();
        start_xfer(MODE_COPY, 19'h00010, 19'h00080, 20'd3, 8'h00);
        wait_done(400, "copy");
        tick();
        check("copy_nops", 32'(op_q.size() - base), 6);
        for (int i = 0; i < 3; i++) begin
            check("copy_rd_op", 32'(op_q[base+2*i]), 32'({1'b0, 19'h00010 + 19'(i)}));
            check("copy_wr_op", 32'(op_q[base+2*i+1]), 32'({1'b1, 19'h00080 + 19'(i)}));
            check("copy_wr_data", 32'(wd_q[base+2*i+1]), 32'(exp_b[i]));
            check("copy_mem", 32'(mem[10'h080 + 10'(i)]), 32'(exp_b[i]));
        end

        // Address wrap at top of SRAM
        base = op_q.size();
        start_xfer(MODE_FILL, 19'h0, 19'h7FFFE, 20'd3, 8'h5A);
        wait_done(400, "wrap");
        tick();
        check("wrap_nops", 32'(op_q.size() - base), 3);
        check("wrap_op0", 32'(op_q[base]), 32'({1'b1, 19'h7FFFE}));
        check("wrap_op1", 32'(op_q[base+1]), 32'({1'b1, 19'h7FFFF}));
        check("wrap_op2", 32'(op_q[base+2]), 32'({1'b1, 19'h00000}));

        // Preemption 40 cycles on 2nd byte: within TIMEOUT
        base = op_q.size();
        long_idx = txn_cnt + 1;
        long_len = 40;
        start_xfer(MODE_FILL, 19'h0, 19'h00200, 20'd3, 8'hC3);
        wait_done(600, "pre40");
        check("pre40_err", 32'(o_err), 0);
        tick();
        check("pre40_nops", 32'(op_q.size() - base), 3);

        // Preemption 100 cycles on 2nd byte: abort with err
        base = op_q.size();
        long_idx = txn_cnt + 1;
        long_len = 100;
        start_xfer(MODE_FILL, 19'h0, 19'h00300, 20'd3, 8'h3C);
        wait_done(600, "tmo");
        check("tmo_err", 32'(o_err), 1);
        check("tmo_rd", 32'(o_rd), 0);
        check("tmo_wr", 32'(o_wr), 0);
        check("tmo_nops", 32'(op_q.size() - base), 1);
        tick();
        check("tmo_busy_low", 32'(o_busy), 0);
        check("tmo_err_sticky", 32'(o_err), 1);
        long_idx = -1;
        wait_idle("tmo");

        // len=0: immediate done, no traffic, err cleared by the start
        base = op_q.size();
        start_xfer(MODE_FILL, 19'h0, 19'h00000, 20'd0, 8'hFF);
        check("len0_done", 32'(o_done), 1);
        check("len0_busy", 32'(o_busy), 0);
        check("len0_err_clr", 32'(o_err), 0);
        tick();
        check("len0_done_low", 32'(o_done), 0);
        repeat (5) tick();
        check("len0_nops", 32'(op_q.size() - base), 0);
        check("len0_no_strobe", 32'(o_rd | o_wr), 0);

        // start while busy is ignored
        base = op_q.size();
        start_xfer(MODE_FILL, 19'h0, 19'h00400, 20'd2, 8'h77);
        repeat (3) tick();
        start_xfer(MODE_COPY, 19'h00000, 19'h00500, 20'd5, 8'h00);
        wait_done(400, "busy_start");
        tick();
        check("bstart_nops", 32'(op_q.size() - base), 2);
        check("bstart_op0", 32'(op_q[base]), 32'({1'b1, 19'h00400}));
        check("bstart_op1", 32'(op_q[base+1]), 32'({1'b1, 19'h00401}));
        check("bstart_data1", 32'(wd_q[base+1]), 32'h077);
        repeat (20) tick();
        check("bstart_quiet", 32'(o_busy), 0);

        // Reset during WR_WAIT of byte 2, then restart while ack is still low
        d0 = done_cnt;
        long_idx = txn_cnt + 1;
        long_len = 50;
        start_xfer(MODE_FILL, 19'h0, 19'h00600, 20'd4, 8'h99);
        begin
            int n;
            n = 0;
            while (txn_cnt < long_idx + 1 && n < 200) begin
                tick();
                n++;
            end
        end
        check("rstx_reached_byte2", 32'(txn_cnt), 32'(long_idx + 1));
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstx_rd", 32'(o_rd), 0);
        check("rstx_wr", 32'(o_wr), 0);
        check("rstx_busy", 32'(o_busy), 0);
        check("rstx_ack_low", 32'(r_ack_m), 0);
        chk_fresh = 1'b1;
        start_xfer(MODE_FILL, 19'h0, 19'h00700, 20'd1, 8'h3C);
        check("rstx_new_busy", 32'(o_busy), 1);
        repeat (5) tick();
        check("rstx_wr_held", 32'(o_wr), 0);
        wait_done(400, "rstx_new");
        tick();
        check("rstx_done_count", 32'(done_cnt - d0), 1);
        check("rstx_last_op", 32'(op_q[op_q.size()-1]), 32'({1'b1, 19'h00700}));
        check("rstx_last_data", 32'(wd_q[wd_q.size()-1]), 32'h03C);
        chk_fresh = 1'b0;
        check("rstx_fresh_edge", 32'(fresh_bad), 0);
        check("rd_wr_exclusive", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
